// File: rtl/conv3x3_frame_ctrl.sv
// Frame-level sequencer for one 3x3 convolution engine.
// Latches a kernel and loads it into the engine with a one-cycle strobe.
// It then accepts a raster pixel stream and builds 3x3 windows from two line
// buffers. One window is issued per interior pixel. Engine result strobes are
// counted, and completion is signalled with a one-cycle frame_done pulse.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   cfg_start           frame start request (honoured in IDLE only)
//   cfg_weights         kernel bytes, weight k at [8k+7:8k], k = 3*row+col
//   pix_in, pix_valid   raster-order pixel stream
//   pix_ready           pixel accepted this cycle when pix_valid is also high
//   conv_weight_en      engine weight-load strobe
//   conv_weights_data   latched kernel
//   conv_data_valid     window strobe to engine
//   win_data            window, byte k = engine data_in_k
//   conv_out_valid      engine result strobe
//   busy                high in every state except IDLE
//   frame_done          one-cycle completion pulse
module conv3x3_frame_ctrl #(
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_start,
    input  logic [71:0] cfg_weights,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        conv_weight_en,
    output logic [71:0] conv_weights_data,
    output logic        conv_data_valid,
    output logic [71:0] win_data,
    input  logic        conv_out_valid,
    output logic        busy,
    output logic        frame_done
);

    localparam int unsigned N_WIN = (IMG_W - 2) * (IMG_H - 2);
    localparam int unsigned XW    = $clog2(IMG_W);
    localparam int unsigned YW    = $clog2(IMG_H);
    localparam int unsigned CW    = $clog2(N_WIN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [XW-1:0]   x_q;
    logic [YW-1:0]   y_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [71:0]     kernel_q;
    logic [71:0]     win_q;
    logic [23:0]     col0_q;        // column x-2, byte r = row y-2+r
    logic [23:0]     col1_q;        // column x-1
    logic            pix_ready_q;
    logic            weight_en_q;
    logic            data_valid_q;
    logic            busy_q;
    logic            done_q;
    logic [7:0]      lb0_q [IMG_W]; // row y-1
    logic [7:0]      lb1_q [IMG_W]; // row y-2

    logic            accept;
    logic            last_pix;
    logic            cnt_en;
    logic            win_fire;
    logic [7:0]      lb_top;
    logic [7:0]      lb_mid;
    logic [71:0]     win_next;

    // Handshake and window-issue qualifiers
    assign accept   = pix_ready_q & pix_valid;
    assign last_pix = (x_q == XW'(IMG_W - 1)) && (y_q == YW'(IMG_H - 1));
    assign cnt_en   = conv_out_valid && ((state_q == S_STREAM) || (state_q == S_DRAIN));
    assign cnt_d    = cnt_q + CW'(cnt_en);
    assign win_fire = accept && (x_q >= XW'(2)) && (y_q >= YW'(2));

    // New column is {pix_in, linebuf0[x], linebuf1[x]}, oldest column in c=0
    assign lb_top   = lb1_q[x_q];
    assign lb_mid   = lb0_q[x_q];
    assign win_next = {pix_in, col1_q[23:16], col0_q[23:16],
                       lb_mid, col1_q[15:8],  col0_q[15:8],
                       lb_top, col1_q[7:0],   col0_q[7:0]};

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (cfg_start) state_d = S_LOAD;
            S_LOAD:   state_d = S_STREAM;
            S_STREAM: if (accept && last_pix) state_d = S_DRAIN;
            // The strobe arriving this edge counts toward completion
            S_DRAIN:  if (cnt_d == CW'(N_WIN)) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM, counters, window and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            cnt_q        <= '0;
            kernel_q     <= '0;
            win_q        <= '0;
            col0_q       <= '0;
            col1_q       <= '0;
            pix_ready_q  <= 1'b0;
            weight_en_q  <= 1'b0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_ready_q  <= (state_d == S_STREAM);
            weight_en_q  <= (state_d == S_LOAD);
            busy_q       <= (state_d != S_IDLE);
            done_q       <= (state_d == S_DONE);
            data_valid_q <= win_fire;

            if ((state_q == S_IDLE) && cfg_start) begin
                kernel_q <= cfg_weights;
            end

            if (win_fire) begin
                win_q <= win_next;
            end

            if (accept) begin
                col0_q <= col1_q;
                col1_q <= {pix_in, lb_mid, lb_top};
            end

            if (state_q == S_DONE) begin
                x_q   <= '0;
                y_q   <= '0;
                cnt_q <= '0;
            end else begin
                if (accept) begin
                    if (x_q == XW'(IMG_W - 1)) begin
                        x_q <= '0;
                        y_q <= (y_q == YW'(IMG_H - 1)) ? '0 : y_q + YW'(1);
                    end else begin
                        x_q <= x_q + XW'(1);
                    end
                end
                cnt_q <= cnt_d;
            end
        end
    end

    // Line buffers: RAM-style storage, contents are not reset
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[x_q] <= lb_mid;
            lb0_q[x_q] <= pix_in;
        end
    end

    assign pix_ready         = pix_ready_q;
    assign conv_weight_en    = weight_en_q;
    assign conv_weights_data = kernel_q;
    assign conv_data_valid   = data_valid_q;
    assign win_data          = win_q;
    assign busy              = busy_q;
    assign frame_done        = done_q;

endmodule

// File: tb/tb_conv3x3_frame_ctrl.sv
// Self-checking bench for conv3x3_frame_ctrl (4x4 frames).
// The driver pushes expected windows into a queue, and a negedge monitor pops
// and compares them. Expected windows come from a 2D image model.
module tb_conv3x3_frame_ctrl;

    localparam int unsigned W    = 4;
    localparam int unsigned H    = 4;
    localparam int unsigned NWIN = (W - 2) * (H - 2);
    localparam logic [71:0] KERN = 72'h090807060504030201;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_start;
    logic [71:0] cfg_weights;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        pix_ready;
    logic        conv_weight_en;
    logic [71:0] conv_weights_data;
    logic        conv_data_valid;
    logic [71:0] win_data;
    logic        conv_out_valid;
    logic        busy;
    logic        frame_done;

    conv3x3_frame_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cfg_start         (cfg_start),
        .cfg_weights       (cfg_weights),
        .pix_in            (pix_in),
        .pix_valid         (pix_valid),
        .pix_ready         (pix_ready),
        .conv_weight_en    (conv_weight_en),
        .conv_weights_data (conv_weights_data),
        .conv_data_valid   (conv_data_valid),
        .win_data          (win_data),
        .conv_out_valid    (conv_out_valid),
        .busy              (busy),
        .frame_done        (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [71:0] win;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [71:0] last_exp = '0;
    logic [7:0]  img [H][W];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          win_cnt  = 0;
    int          wen_cnt  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk72(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Window centred on (yc, xc) taken straight from the image
    function automatic logic [71:0] ref_window(input int yc, input int xc);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[8*(3*r+c) +: 8] = img[yc-1+r][xc-1+c];
        return w;
    endfunction

    // Monitor: every window strobe is matched against the queue; between
    // strobes win_data must keep the last expected window.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_exp = '0;
        end else begin
            if (conv_weight_en) wen_cnt++;
            if (conv_data_valid) begin
                win_cnt++;
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_window: win_data=%h with none expected", win_data);
                end else begin
                    mon_e = q.pop_front();
                    chk72("win_data", win_data, mon_e.win);
                    chk_int("win_latency_cycle", cyc, mon_e.cyc);
                    last_exp = mon_e.win;
                end
            end else begin
                chk72("win_data_hold", win_data, last_exp);
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk1({tag, "_pix_ready"}, pix_ready, 1'b0);
        chk1({tag, "_weight_en"}, conv_weight_en, 1'b0);
        chk72({tag, "_weights_data"}, conv_weights_data, 72'h0);
        chk1({tag, "_data_valid"}, conv_data_valid, 1'b0);
        chk72({tag, "_win_data"}, win_data, 72'h0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_frame_done"}, frame_done, 1'b0);
    endtask

    // vmode: 0 continuous valid, 1 toggling 1-0-1-0, 2 random valid
    task automatic run_frame(input logic [71:0] wts, input int vmode, input bit rnd_pix,
                             input bit poke, input int stop_after);
        int idx, budget, x, y, win0, wen0;
        bit phase, poked, v;
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++)
                img[yy][xx] = rnd_pix ? 8'($urandom) : 8'(W * yy + xx);
        win0 = win_cnt;
        wen0 = wen_cnt;

        cfg_weights = wts;
        cfg_start   = 1'b1;
        @(negedge clk);
        cfg_start   = 1'b0;
        cfg_weights = {8'($urandom), $urandom, $urandom};
        chk1("load_weight_en", conv_weight_en, 1'b1);
        chk72("load_weights_data", conv_weights_data, wts);
        chk1("load_busy", busy, 1'b1);
        chk1("load_pix_ready", pix_ready, 1'b0);
        @(negedge clk);
        chk1("stream_weight_en", conv_weight_en, 1'b0);
        chk1("stream_pix_ready", pix_ready, 1'b1);

        idx    = 0;
        budget = 400;
        phase  = 1'b1;
        poked  = 1'b0;
        while (idx < stop_after && budget > 0) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = phase;
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            phase     = !phase;
            pix_valid = v;
            pix_in    = img[idx / W][idx % W];
            cfg_start = poke && !poked && (idx == 6);
            if (cfg_start) begin
                cfg_weights = ~wts;
                poked       = 1'b1;
            end
            if (v && pix_ready) begin
                y = idx / W;
                x = idx % W;
                if (y >= 2 && x >= 2) q.push_back('{ref_window(y - 1, x - 1), cyc + 1});
                idx++;
            end
            @(negedge clk);
            budget--;
        end
        pix_valid = 1'b0;
        cfg_start = 1'b0;
        if (idx < stop_after) begin
            checks++;
            failures++;
            $display("FAIL stream_timeout: accepted %0d pixels expected %0d", idx, stop_after);
        end
        if (stop_after < W * H) return;

        chk1("pix_ready_after_last", pix_ready, 1'b0);
        chk72("kernel_held", conv_weights_data, wts);

        // Result strobes; the last one lands 5 cycles after the final window
        for (int t = 0; t <= 5; t++) begin
            conv_out_valid = (t == 1 || t == 2 || t == 4 || t == 5);
            @(negedge clk);
            chk1("frame_done_timing", frame_done, t == 5);
            chk1("busy_drain", busy, 1'b1);
        end
        conv_out_valid = 1'b0;
        @(negedge clk);
        chk1("frame_done_clear", frame_done, 1'b0);
        chk1("busy_idle", busy, 1'b0);
        chk_int("windows_per_frame", win_cnt - win0, NWIN);
        chk_int("queue_empty", q.size(), 0);
        chk_int("weight_loads_per_frame", wen_cnt - wen0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n          = 1'b0;
        cfg_start      = 1'b0;
        cfg_weights    = '0;
        pix_in         = '0;
        pix_valid      = 1'b0;
        conv_out_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Result strobes in IDLE must not count toward the next frame
        conv_out_valid = 1'b1;
        @(negedge clk);
        conv_out_valid = 1'b0;
        @(negedge clk);
        conv_out_valid = 1'b1;
        @(negedge clk);
        conv_out_valid = 1'b0;
        chk1("idle_busy", busy, 1'b0);

        run_frame(KERN, 0, 1'b0, 1'b0, W * H);
        run_frame(KERN, 1, 1'b0, 1'b1, W * H);
        run_frame({8'($urandom), $urandom, $urandom}, 2, 1'b1, 1'b0, W * H);

        // Reset after 7 pixels, then a complete frame
        run_frame(KERN, 0, 1'b0, 1'b0, 7);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midframe_reset");
        q.delete();
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset_hold");
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(KERN, 0, 1'b0, 1'b0, W * H);
        run_frame({8'($urandom), $urandom, $urandom}, 2, 1'b1, 1'b1, W * H);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
